// File: rtl/seg7_scan_ctrl_if.sv
// Source-select, display-option and LED pin bundle for the 7-segment scan controller.
// master drives the debug words and options; slave owns the LED pins and frame strobe.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_SRC    = 10
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*DW-1:0] src_bus;
    logic [SW-1:0]         src_sel;
    logic                  freeze;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [NUM_DIGITS-1:0] LEDSEL;
    logic [7:0]            LEDOUT;
    logic                  frame_done;

    modport master (
        output src_bus, src_sel, freeze, blank_lz, dp_mask,
        input  LEDSEL, LEDOUT, frame_done
    );

    modport slave (
        input  src_bus, src_sel, freeze, blank_lz, dp_mask,
        output LEDSEL, LEDOUT, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display: latches one selected word per frame and scans it digit by digit.
// LED pins are registered one cycle behind the scan state; no backpressure, free-running scan.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_SRC    = 10,
    parameter int SCAN_DIV   = 20000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0]         PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         DIDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            LED_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         didx;
    logic [DW-1:0]         disp_word;
    logic                  blank_q;
    logic                  tick;
    logic                  frame_end;
    logic                  load;
    logic [DW-1:0]         sel_word;
    logic [NUM_DIGITS-1:0] lz;
    logic                  zacc;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] sel_ah;
    logic [7:0]            led_ah;
    logic [NUM_DIGITS-1:0] sel_nxt;
    logic [7:0]            led_nxt;

    // Segment patterns g..a, 0 = lit, dp excluded
    function automatic logic [6:0] font_al(input logic [3:0] n);
        font_al = 7'h7F;
        case (n)
            4'h0: font_al = 7'h40;
            4'h1: font_al = 7'h79;
            4'h2: font_al = 7'h24;
            4'h3: font_al = 7'h30;
            4'h4: font_al = 7'h19;
            4'h5: font_al = 7'h12;
            4'h6: font_al = 7'h02;
            4'h7: font_al = 7'h78;
            4'h8: font_al = 7'h00;
            4'h9: font_al = 7'h10;
            4'hA: font_al = 7'h08;
            4'hB: font_al = 7'h03;
            4'hC: font_al = 7'h46;
            4'hD: font_al = 7'h21;
            4'hE: font_al = 7'h06;
            4'hF: font_al = 7'h0E;
        endcase
    endfunction

    assign tick      = (pcnt == PCNT_LAST);
    assign frame_end = tick && (didx == DIDX_LAST);
    assign load      = frame_end && !bus.freeze;

    // Out-of-range selects fall through to source 0
    always_comb begin
        sel_word = bus.src_bus[DW-1:0];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_sel == SW'(i)) begin
                sel_word = bus.src_bus[i*DW +: DW];
            end
        end
    end

    // lz[k] set when nibbles k..top are all zero
    always_comb begin
        zacc = 1'b1;
        lz   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zacc  = zacc & (disp_word[4*k +: 4] == 4'h0);
            lz[k] = zacc;
        end
    end

    always_comb begin
        cur_nib   = disp_word[3:0];
        cur_blank = 1'b0;
        cur_dp    = bus.dp_mask[0];
        sel_ah    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (didx == IW'(k)) begin
                cur_nib   = disp_word[4*k +: 4];
                cur_blank = blank_q && (k != 0) && lz[k];
                cur_dp    = bus.dp_mask[k];
                sel_ah[k] = 1'b1;
            end
        end
        led_ah = {cur_dp, cur_blank ? 7'h00 : ~font_al(cur_nib)};
        if (ACTIVE_LOW != 0) begin
            sel_nxt = ~sel_ah;
            led_nxt = ~led_ah;
        end else begin
            sel_nxt = sel_ah;
            led_nxt = led_ah;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt           <= '0;
            didx           <= '0;
            disp_word      <= '0;
            blank_q        <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.LEDSEL     <= SEL_OFF;
            bus.LEDOUT     <= LED_OFF;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) begin
                didx <= (didx == DIDX_LAST) ? '0 : didx + IW'(1);
            end
            if (load) begin
                disp_word <= sel_word;
                blank_q   <= bus.blank_lz;
            end
            bus.frame_done <= load;
            bus.LEDSEL     <= sel_nxt;
            bus.LEDOUT     <= led_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: 4 digits, 10 sources, 4-cycle dwell, active-low pins.
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int NS = 10;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND), .NUM_SRC(NS)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .NUM_SRC(NS), .SCAN_DIV(SD), .ACTIVE_LOW(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] sel_e;
        logic [7:0] out_e;
        logic       fd_e;
    } exp_t;

    typedef struct {
        logic [3:0]      sel;
        int              src;
        logic [15:0]     word;
        logic            blank;
        logic [3:0]      dp;
        logic [3:0][7:0] code;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    logic [15:0] words[NS];
    int          tests = 0;
    int          fails = 0;

    function automatic vec_t mk(input logic [3:0] sel, input int src, input logic [15:0] w,
                                input logic b, input logic [3:0] dp,
                                input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic [7:0] c3);
        vec_t v;
        v.sel   = sel;
        v.src   = src;
        v.word  = w;
        v.blank = b;
        v.dp    = dp;
        v.code  = {c3, c2, c1, c0};
        return v;
    endfunction

    task automatic drive_words();
        for (int i = 0; i < NS; i++) bus.src_bus[i*16 +: 16] = words[i];
    endtask

    task automatic push_range(input logic [3:0][7:0] code, input logic [3:0] dp,
                              input logic fd_last, input int jlo, input int jhi);
        exp_t e;
        for (int j = jlo; j <= jhi; j++) begin
            e.sel_e = ~(4'b0001 << (j / SD));
            e.out_e = code[j / SD];
            if (dp[j / SD]) e.out_e[7] = 1'b0;
            e.fd_e  = (j == ND * SD - 1) && fd_last;
            sb.push_back(e);
        end
    endtask

    task automatic check_one(input string name);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got sel=%b out=%h fd=%b", name,
                     bus.LEDSEL, bus.LEDOUT, bus.frame_done);
            return;
        end
        e = sb.pop_front();
        if (bus.LEDSEL !== e.sel_e || bus.LEDOUT !== e.out_e || bus.frame_done !== e.fd_e) begin
            fails++;
            $display("FAIL %s: got sel=%b out=%h fd=%b, want sel=%b out=%h fd=%b", name,
                     bus.LEDSEL, bus.LEDOUT, bus.frame_done, e.sel_e, e.out_e, e.fd_e);
        end
    endtask

    task automatic step_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_one(name);
        end
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.frame_done && n < 3 * ND * SD);
        tests++;
        if (bus.frame_done !== 1'b1) begin
            fails++;
            $display("FAIL %s: frame_done timeout, got fd=%b after %0d cycles, want 1", name,
                     bus.frame_done, n);
        end
    endtask

    initial begin
        logic [3:0][7:0] c_12af;
        logic [3:0][7:0] c_3456;
        logic [3:0][7:0] c_zero;
        logic [3:0][7:0] c_ffff;
        exp_t            e_rst;

        c_12af = {8'hF9, 8'hA4, 8'h88, 8'h8E};
        c_3456 = {8'hB0, 8'h99, 8'h92, 8'h82};
        c_zero = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
        c_ffff = {8'h8E, 8'h8E, 8'h8E, 8'h8E};
        e_rst  = '{sel_e: 4'hF, out_e: 8'hFF, fd_e: 1'b0};

        vecs[0] = mk(4'd2, 2, 16'h12AF, 1'b0, 4'b0000, 8'h8E, 8'h88, 8'hA4, 8'hF9);
        vecs[1] = mk(4'd12, 0, 16'h00C3, 1'b0, 4'b0000, 8'hB0, 8'hC6, 8'hC0, 8'hC0);
        vecs[2] = mk(4'd1, 1, 16'h0050, 1'b1, 4'b0000, 8'hC0, 8'h92, 8'hFF, 8'hFF);
        vecs[3] = mk(4'd1, 1, 16'h0000, 1'b1, 4'b1000, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        vecs[4] = mk(4'd4, 4, 16'h0050, 1'b0, 4'b0010, 8'hC0, 8'h92, 8'hC0, 8'hC0);
        vecs[5] = mk(4'd9, 9, 16'hBD07, 1'b1, 4'b1001, 8'hF8, 8'hC0, 8'hA1, 8'h83);
        vecs[6] = mk(4'd5, 5, 16'h0900, 1'b1, 4'b0000, 8'hC0, 8'hC0, 8'h90, 8'hFF);

        for (int i = 0; i < NS; i++) words[i] = 16'h1111 * i[15:0] + 16'h0101;
        words[0] = 16'h00C3;
        drive_words();
        bus.src_sel  = '0;
        bus.freeze   = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = '0;

        // Power-on reset, then the first frame of the cleared word
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(e_rst);
        check_one("por");
        rst = 1'b0;
        push_range(c_zero, 4'b0000, 1'b1, 0, ND*SD-1);
        step_check(ND*SD, "first_frame");

        // Reset mid-scan: word 00C3 was loaded and must be discarded
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(e_rst);
        check_one("mid_rst");
        rst = 1'b0;
        push_range(c_zero, 4'b0000, 1'b1, 0, ND*SD-1);
        step_check(ND*SD, "post_rst");

        for (int i = 0; i < 7; i++) begin
            words[vecs[i].src] = vecs[i].word;
            drive_words();
            bus.src_sel  = vecs[i].sel;
            bus.blank_lz = vecs[i].blank;
            bus.dp_mask  = vecs[i].dp;
            wait_fd($sformatf("vec%0d_load", i));
            push_range(vecs[i].code, vecs[i].dp, 1'b1, 0, ND*SD-1);
            step_check(ND*SD, $sformatf("vec%0d", i));
        end

        // src_sel change mid-frame stays hidden until the next boundary
        words[2] = 16'h12AF;
        words[3] = 16'h3456;
        drive_words();
        bus.src_sel  = 4'd2;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = '0;
        wait_fd("sel_load");
        push_range(c_12af, 4'b0000, 1'b1, 0, ND*SD-1);
        step_check(6, "sel_hold_a");
        bus.src_sel = 4'd3;
        step_check(ND*SD - 6, "sel_hold_b");
        push_range(c_3456, 4'b0000, 1'b1, 0, 1);
        step_check(2, "sel_new");

        // dp_mask reaches the pins on the very next cycle
        bus.dp_mask = 4'b0001;
        push_range(c_3456, 4'b0001, 1'b1, 2, ND*SD-1);
        step_check(ND*SD - 2, "dp_live");

        // Freeze across two boundaries while the source changes
        bus.dp_mask = '0;
        bus.freeze  = 1'b1;
        words[3]    = 16'hFFFF;
        drive_words();
        push_range(c_3456, 4'b0000, 1'b0, 0, ND*SD-1);
        push_range(c_3456, 4'b0000, 1'b0, 0, ND*SD-1);
        step_check(2*ND*SD, "freeze");
        bus.freeze = 1'b0;
        wait_fd("unfreeze_load");
        push_range(c_ffff, 4'b0000, 1'b1, 0, ND*SD-1);
        step_check(ND*SD, "unfreeze");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
